// File: rtl/rom_msg_pkg.sv
// Shared constants for the ROM message streamer: ROM geometry, default terminator, FSM encoding.
// Pure declarations; no timing or flow-control behaviour lives here.
package rom_msg_pkg;

  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 8;

  localparam logic [7:0] TERM_DEFAULT = 8'h00;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SEND   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

endpackage

// File: rtl/rom_msg_streamer.sv
// Streams a terminator-delimited message out of a registered-read pROM; first byte valid 3 cycles after start, then 1 byte per 3 cycles.
// tx_ready low holds the current byte stable in SEND indefinitely; start is ignored while busy.
module rom_msg_streamer
  import rom_msg_pkg::*;
#(
  parameter int                ADDR_W = ROM_ADDR_W,
  parameter int                DATA_W = ROM_DATA_W,
  parameter logic [DATA_W-1:0] TERM   = DATA_W'(TERM_DEFAULT)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [ADDR_W-1:0] addr;
  logic              is_term;
  logic              handshake;
  logic              at_last;

  assign rom_ad    = addr;
  assign rom_oce   = 1'b1;
  assign rom_reset = 1'b0;

  assign is_term   = (rom_dout == TERM);
  assign handshake = (state == ST_SEND) && tx_ready;
  assign at_last   = (addr == LAST_ADDR);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_FETCH;
      ST_FETCH:  next_state = ST_WAIT;
      // rom_dout carries the byte fetched in the previous cycle
      ST_WAIT:   next_state = is_term ? ST_FINISH : ST_SEND;
      ST_SEND:   if (tx_ready) next_state = at_last ? ST_FINISH : ST_FETCH;
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Status outputs are registered off next_state so they line up with state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      addr     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_ce   <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      state  <= next_state;
      busy   <= (next_state != ST_IDLE);
      done   <= (next_state == ST_FINISH);
      rom_ce <= (next_state == ST_FETCH);

      if (state == ST_IDLE && start)
        addr <= start_addr;
      else if (handshake && !at_last)
        addr <= addr + 1'b1;

      if (state == ST_WAIT && !is_term) begin
        tx_data  <= rom_dout;
        tx_valid <= 1'b1;
      end else if (handshake) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_msg_streamer.sv
// Directed bench for rom_msg_streamer with a registered-read 16x8 pROM model holding "ABCDEFGHIPQRSTU",00.
module tb_rom_msg_streamer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [3:0] start_addr;
  logic       busy;
  logic       done;
  logic [3:0] rom_ad;
  logic       rom_ce;
  logic       rom_oce;
  logic       rom_reset;
  logic [7:0] rom_dout;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  always #5 clk = ~clk;

  rom_msg_streamer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .start_addr (start_addr),
    .busy       (busy),
    .done       (done),
    .rom_ad     (rom_ad),
    .rom_ce     (rom_ce),
    .rom_oce    (rom_oce),
    .rom_reset  (rom_reset),
    .rom_dout   (rom_dout),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  // ROM contents, also the expected byte table
  logic [7:0] rom_mem [16];
  initial begin
    rom_mem = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48,
                8'h49, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h00};
  end

  // Registered read: data appears the cycle after ce
  always @(posedge clk) begin
    if (rom_reset) rom_dout <= 8'h00;
    else if (rom_ce) rom_dout <= rom_mem[rom_ad];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from DUT updates
  logic [7:0] q [$];
  int         hs_cyc [$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         ce_cnt = 0;
  int         valid_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn) begin
      if (tx_valid && tx_ready) begin
        q.push_back(tx_data);
        hs_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      if (rom_ce) ce_cnt++;
      if (tx_valid) valid_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] a);
    start      = 1'b1;
    start_addr = a;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int base, input int cnt);
    int n = 0;
    while (q.size() - base < cnt && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_bytes_seen"}, 32'(q.size() - base >= cnt), 32'd1);
  endtask

  task automatic check_msg(input string tag, input int base, input int first, input int n);
    chk({tag, "_len"}, 32'(q.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < q.size(); i++)
      chk({tag, "_byte"}, 32'(q[base + i]), 32'(rom_mem[first + i]));
  endtask

  int qb, d0, c0, v0, bad, n;

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    start_addr = 4'd0;
    tx_ready   = 1'b1;
    @(negedge clk);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_done",     32'(done),      32'd0);
    chk("rst_rom_ce",   32'(rom_ce),    32'd0);
    chk("rst_tx_valid", 32'(tx_valid),  32'd0);
    chk("rst_tx_data",  32'(tx_data),   32'd0);
    chk("rst_rom_ad",   32'(rom_ad),    32'd0);
    chk("rom_oce",      32'(rom_oce),   32'd1);
    chk("rom_reset",    32'(rom_reset), 32'd0);
    step();
    resetn = 1'b1;
    step();

    // Full message from 0 with latency and throughput
    qb = q.size(); d0 = done_cnt; c0 = ce_cnt;
    pulse_start(4'd0);
    chk("t1_fetch_busy", 32'(busy),     32'd1);
    chk("t1_fetch_ce",   32'(rom_ce),   32'd1);
    chk("t1_fetch_ad",   32'(rom_ad),   32'd0);
    step();
    chk("t1_wait_ce",    32'(rom_ce),   32'd0);
    chk("t1_wait_valid", 32'(tx_valid), 32'd0);
    step();
    chk("t1_send_valid", 32'(tx_valid), 32'd1);
    chk("t1_send_data",  32'(tx_data),  32'h41);
    wait_done("t1", d0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_done", 32'(done), 32'd0);
    check_msg("t1", qb, 0, 15);
    bad = 0;
    for (int i = qb + 1; i < hs_cyc.size(); i++)
      if (hs_cyc[i] - hs_cyc[i-1] != 3) bad++;
    chk("t1_gap3", 32'(bad), 32'd0);
    chk("t1_ce_cnt", 32'(ce_cnt - c0), 32'd16);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    step();

    // Mid-table start
    qb = q.size(); d0 = done_cnt; c0 = ce_cnt;
    pulse_start(4'd9);
    wait_done("t2", d0);
    check_msg("t2", qb, 9, 6);
    chk("t2_ce_cnt", 32'(ce_cnt - c0), 32'd7);
    step();

    // Terminator at start address
    d0 = done_cnt; v0 = valid_cnt;
    pulse_start(4'd15);
    chk("t3_busy", 32'(busy), 32'd1);
    step();
    chk("t3_n2_done", 32'(done), 32'd0);
    step();
    chk("t3_n3_done", 32'(done), 32'd1);
    step();
    chk("t3_after_done", 32'(done), 32'd0);
    chk("t3_after_busy", 32'(busy), 32'd0);
    chk("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);
    step();

    // Stall on byte 3
    qb = q.size(); d0 = done_cnt;
    pulse_start(4'd0);
    wait_bytes("t4", qb, 2);
    tx_ready = 1'b0;
    n = 0;
    while (!tx_valid && n < 20) begin
      step();
      n++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'h43) bad++;
      step();
    end
    chk("t4_stall_stable", 32'(bad), 32'd0);
    chk("t4_stall_len", 32'(q.size() - qb), 32'd2);
    tx_ready = 1'b1;
    wait_done("t4", d0);
    check_msg("t4", qb, 0, 15);
    step();

    // Start while busy is ignored
    qb = q.size(); d0 = done_cnt;
    pulse_start(4'd0);
    wait_bytes("t5", qb, 3);
    pulse_start(4'd9);
    wait_done("t5", d0);
    for (int i = 0; i < 20; i++) step();
    check_msg("t5", qb, 0, 15);
    chk("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);

    // Reset during SEND of byte 6
    qb = q.size(); d0 = done_cnt;
    pulse_start(4'd0);
    wait_bytes("t6", qb, 5);
    tx_ready = 1'b0;
    n = 0;
    while (!tx_valid && n < 20) begin
      step();
      n++;
    end
    chk("t6_byte6", 32'(tx_data), 32'h46);
    resetn = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(tx_valid), 32'd0);
    chk("t6_rst_busy",  32'(busy),     32'd0);
    chk("t6_rst_data",  32'(tx_data),  32'd0);
    chk("t6_rst_ad",    32'(rom_ad),   32'd0);
    step();
    step();
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    resetn   = 1'b1;
    tx_ready = 1'b1;
    step();
    qb = q.size(); d0 = done_cnt;
    pulse_start(4'd0);
    wait_done("t6", d0);
    check_msg("t6", qb, 0, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
